// File: rtl/calc_seg_pkg.sv
// Shared definitions for the calculator entry path: active-low 7-segment
// codes, keypad key codes and the entry FSM state encoding.
package calc_seg_pkg;

    // Active-low segment codes, bit order abcdefg
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_PLUS  = 7'b1101100;
    localparam logic [6:0] SEG_MIN   = 7'b1111110;
    localparam logic [6:0] SEG_MULT  = 7'b1001000;
    localparam logic [6:0] SEG_DIV   = 7'b1011011;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Keypad codes above the digits
    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MIN   = 4'd11;
    localparam logic [3:0] KEY_MULT  = 4'd12;
    localparam logic [3:0] KEY_DIV   = 4'd13;
    localparam logic [3:0] KEY_EQ    = 4'd14;
    localparam logic [3:0] KEY_CLEAR = 4'd15;

    typedef enum logic [2:0] {
        ST_NUM1 = 3'd0,
        ST_OP   = 3'd1,
        ST_NUM2 = 3'd2,
        ST_CALC = 3'd3,
        ST_SHOW = 3'd4
    } state_t;

    // Segment code for an operator key; callers only pass operator codes
    function automatic logic [6:0] op_seg(input logic [3:0] code);
        case (code)
            KEY_MIN:  return SEG_MIN;
            KEY_MULT: return SEG_MULT;
            KEY_DIV:  return SEG_DIV;
            default:  return SEG_PLUS;
        endcase
    endfunction

endpackage

// File: rtl/digit_to_seg.sv
// Combinational BCD digit to active-low 7-segment encoder.
// Codes 10-15 produce a blank pattern.
module digit_to_seg
    import calc_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad operand entry sequencer for the calculator datapath.
// Operands are held as BCD digits and encoded to 7-segment on the way out,
// so unentered positions naturally read as seg0.
// Optional inactivity auto-clear: define CALC_TIMEOUT_EN.
module calc_entry_ctrl
    import calc_seg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        calc_done,
    output logic [20:0] Ssegnum1,
    output logic [20:0] Ssegnum2,
    output logic [6:0]  signo1,
    output logic [6:0]  operador,
    output logic        calc_start,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    state_t      state, state_n;
    logic [11:0] num1, num1_n;   // {hundreds, tens, units} BCD
    logic [11:0] num2, num2_n;
    logic [1:0]  cnt1, cnt1_n;   // digits entered so far
    logic [1:0]  cnt2, cnt2_n;
    logic [6:0]  sign, sign_n;
    logic [6:0]  op, op_n;
    logic        start_n;
    logic        timeout;
    logic        is_digit, is_oper;

    assign is_digit = (key_code <= 4'd9);
    assign is_oper  = (key_code >= KEY_PLUS) && (key_code <= KEY_DIV);

`ifdef CALC_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] idle_cnt;
    logic          entry_state;

    assign entry_state = (state == ST_NUM1) || (state == ST_OP) || (state == ST_NUM2);
    assign timeout     = entry_state && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Inactivity counter: restarts on any key, holds outside the entry states
    always_ff @(posedge clk) begin
        if (rst || key_valid || timeout) begin
            idle_cnt <= '0;
        end else if (entry_state) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State and operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_NUM1;
            num1       <= '0;
            num2       <= '0;
            cnt1       <= '0;
            cnt2       <= '0;
            sign       <= SEG_BLANK;
            op         <= SEG_PLUS;
            calc_start <= 1'b0;
        end else begin
            state      <= state_n;
            num1       <= num1_n;
            num2       <= num2_n;
            cnt1       <= cnt1_n;
            cnt2       <= cnt2_n;
            sign       <= sign_n;
            op         <= op_n;
            calc_start <= start_n;
        end
    end

    // Next-state decode; clear (key or timeout) takes priority over everything
    always_comb begin
        state_n = state;
        num1_n  = num1;
        num2_n  = num2;
        cnt1_n  = cnt1;
        cnt2_n  = cnt2;
        sign_n  = sign;
        op_n    = op;
        start_n = 1'b0;

        if ((key_valid && key_code == KEY_CLEAR) || timeout) begin
            state_n = ST_NUM1;
            num1_n  = '0;
            num2_n  = '0;
            cnt1_n  = '0;
            cnt2_n  = '0;
            sign_n  = SEG_BLANK;
            op_n    = SEG_PLUS;
        end else begin
            case (state)
                ST_NUM1: begin
                    if (key_valid) begin
                        if (is_digit) begin
                            if (cnt1 != 2'd3) begin
                                num1_n = {num1[7:0], key_code};
                                cnt1_n = cnt1 + 2'd1;
                            end
                        end else if (cnt1 == 2'd0 && key_code == KEY_MIN) begin
                            sign_n = (sign == SEG_BLANK) ? SEG_MIN : SEG_BLANK;
                        end else if (cnt1 != 2'd0 && is_oper) begin
                            op_n    = op_seg(key_code);
                            state_n = ST_OP;
                        end
                    end
                end
                ST_OP: begin
                    if (key_valid) begin
                        if (is_oper) begin
                            op_n = op_seg(key_code);
                        end else if (is_digit) begin
                            num2_n  = {8'h00, key_code};
                            cnt2_n  = 2'd1;
                            state_n = ST_NUM2;
                        end
                    end
                end
                ST_NUM2: begin
                    if (key_valid) begin
                        if (is_digit) begin
                            if (cnt2 != 2'd3) begin
                                num2_n = {num2[7:0], key_code};
                                cnt2_n = cnt2 + 2'd1;
                            end
                        end else if (key_code == KEY_EQ) begin
                            start_n = 1'b1;
                            state_n = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (calc_done) begin
                        state_n = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (key_valid) begin
                        if (is_digit) begin
                            num1_n  = {8'h00, key_code};
                            cnt1_n  = 2'd1;
                            num2_n  = '0;
                            cnt2_n  = '0;
                            sign_n  = SEG_BLANK;
                            op_n    = SEG_PLUS;
                            state_n = ST_NUM1;
                        end else if (is_oper) begin
                            op_n    = op_seg(key_code);
                            num2_n  = '0;
                            cnt2_n  = '0;
                            state_n = ST_OP;
                        end
                    end
                end
                default: state_n = ST_NUM1;
            endcase
        end
    end

    digit_to_seg u_n1_h (.digit(num1[11:8]), .seg(Ssegnum1[20:14]));
    digit_to_seg u_n1_t (.digit(num1[7:4]),  .seg(Ssegnum1[13:7]));
    digit_to_seg u_n1_u (.digit(num1[3:0]),  .seg(Ssegnum1[6:0]));
    digit_to_seg u_n2_h (.digit(num2[11:8]), .seg(Ssegnum2[20:14]));
    digit_to_seg u_n2_t (.digit(num2[7:4]),  .seg(Ssegnum2[13:7]));
    digit_to_seg u_n2_u (.digit(num2[3:0]),  .seg(Ssegnum2[6:0]));

    assign signo1    = sign;
    assign operador  = op;
    assign busy      = (state == ST_CALC);
    assign state_dbg = state;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed self-checking bench for calc_entry_ctrl.
// The inactivity section runs only when CALC_TIMEOUT_EN is defined.
module tb_calc_entry_ctrl;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] PLUS  = 7'b1101100;
    localparam logic [6:0] MINUS = 7'b1111110;
    localparam logic [6:0] MULT  = 7'b1001000;
    localparam logic [6:0] DIV   = 7'b1011011;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        calc_done = 1'b0;
    logic [20:0] Ssegnum1, Ssegnum2;
    logic [6:0]  signo1, operador;
    logic        calc_start, busy;
    logic [2:0]  state_dbg;

    int tests = 0;
    int failed = 0;

    calc_entry_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .calc_done(calc_done), .Ssegnum1(Ssegnum1), .Ssegnum2(Ssegnum2),
        .signo1(signo1), .operador(operador), .calc_start(calc_start),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " state"},  32'(state_dbg), 32'd0);
        chk({tag, " num1"},   32'(Ssegnum1), 32'({S0, S0, S0}));
        chk({tag, " num2"},   32'(Ssegnum2), 32'({S0, S0, S0}));
        chk({tag, " sign"},   32'(signo1), 32'(BLANK));
        chk({tag, " op"},     32'(operador), 32'(PLUS));
        chk({tag, " start"},  32'(calc_start), 32'd0);
        chk({tag, " busy"},   32'(busy), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk_reset_vals("reset");

        // Three digits, fourth ignored
        press(4'd1);
        press(4'd2);
        press(4'd3);
        chk("num1_123", 32'(Ssegnum1), 32'({S1, S2, S3}));
        press(4'd4);
        chk("num1_4th_ignored", 32'(Ssegnum1), 32'({S1, S2, S3}));
        chk("num1_state", 32'(state_dbg), 32'd0);

        // Clear back to reset values
        press(4'd15);
        chk_reset_vals("clear1");

        // Minus toggles sign before digits
        press(4'd11);
        chk("sign_neg", 32'(signo1), 32'(MINUS));
        press(4'd11);
        chk("sign_toggle_back", 32'(signo1), 32'(BLANK));
        press(4'd11);
        press(4'd7);
        chk("sign_neg2", 32'(signo1), 32'(MINUS));
        chk("num1_7", 32'(Ssegnum1), 32'({S0, S0, S7}));
        press(4'd14);
        chk("eq_in_num1_ignored", 32'(state_dbg), 32'd0);
        press(4'd12);
        chk("op_mult", 32'(operador), 32'(MULT));
        chk("state_op", 32'(state_dbg), 32'd1);
        press(4'd5);
        chk("num2_5", 32'(Ssegnum2), 32'({S0, S0, S5}));
        chk("state_num2", 32'(state_dbg), 32'd2);
        press(4'd14);
        chk("start_pulse", 32'(calc_start), 32'd1);
        chk("busy_rise", 32'(busy), 32'd1);
        chk("state_calc", 32'(state_dbg), 32'd3);
        press(4'd3);
        chk("start_one_cycle", 32'(calc_start), 32'd0);
        chk("busy_held", 32'(busy), 32'd1);
        chk("calc_key_ignored", 32'(Ssegnum2), 32'({S0, S0, S5}));
        tick();
        chk("busy_held2", 32'(busy), 32'd1);
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        chk("state_show", 32'(state_dbg), 32'd4);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("show_num1_frozen", 32'(Ssegnum1), 32'({S0, S0, S7}));
        chk("show_num2_frozen", 32'(Ssegnum2), 32'({S0, S0, S5}));

        // Digit in SHOW starts a fresh operand 1
        press(4'd4);
        chk("show_digit_state", 32'(state_dbg), 32'd0);
        chk("show_digit_num1", 32'(Ssegnum1), 32'({S0, S0, S4}));
        chk("show_digit_num2", 32'(Ssegnum2), 32'({S0, S0, S0}));
        chk("show_digit_sign", 32'(signo1), 32'(BLANK));

        // Held key_valid counts once per cycle
        key_valid = 1'b1;
        key_code  = 4'd5;
        tick();
        tick();
        key_valid = 1'b0;
        chk("held_key", 32'(Ssegnum1), 32'({S4, S5, S5}));

        // Operator replacement in OP, operators ignored in NUM2
        press(4'd10);
        press(4'd13);
        chk("op_replace_div", 32'(operador), 32'(DIV));
        press(4'd9);
        chk("op_digit_num2", 32'(state_dbg), 32'd2);
        chk("num2_9", 32'(Ssegnum2), 32'({S0, S0, S9}));
        press(4'd10);
        chk("num2_op_ignored", 32'(operador), 32'(DIV));
        press(4'd14);
        chk("start_pulse2", 32'(calc_start), 32'd1);

        // Clear and calc_done together: clear wins
        key_valid = 1'b1;
        key_code  = 4'd15;
        calc_done = 1'b1;
        tick();
        key_valid = 1'b0;
        calc_done = 1'b0;
        chk_reset_vals("clear_vs_done");

        // calc_done coincident with calc_start
        press(4'd2);
        press(4'd10);
        press(4'd3);
        press(4'd14);
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        chk("done_with_start_state", 32'(state_dbg), 32'd4);
        chk("done_with_start_pulse", 32'(calc_start), 32'd0);

        // Operator in SHOW keeps operand 1, clears operand 2
        press(4'd12);
        chk("show_op_state", 32'(state_dbg), 32'd1);
        chk("show_op_num1", 32'(Ssegnum1), 32'({S0, S0, S2}));
        chk("show_op_num2", 32'(Ssegnum2), 32'({S0, S0, S0}));
        chk("show_op_op", 32'(operador), 32'(MULT));

        // Reset mid-CALC, then a stray calc_done
        press(4'd1);
        press(4'd14);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst_mid_calc");
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        chk("late_done_ignored", 32'(state_dbg), 32'd0);
        tick();
        chk("no_start_after_rst", 32'(calc_start), 32'd0);

`ifdef CALC_TIMEOUT_EN
        press(4'd3);
        repeat (15) tick();
        chk("timeout_not_yet", 32'(Ssegnum1), 32'({S0, S0, S3}));
        tick();
        chk_reset_vals("timeout_clear");
        press(4'd1);
        press(4'd10);
        press(4'd2);
        press(4'd14);
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        repeat (20) tick();
        chk("show_no_timeout", 32'(state_dbg), 32'd4);
        chk("show_no_timeout_num1", 32'(Ssegnum1), 32'({S0, S0, S1}));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
